can_rx_destuff: RTL
===================

Name: can_rx_destuff

Overview:
- Receive-path stage directly downstream of the CAN bit sampler.
- Consumes the sampler's registered `dout` stream and removes stuff bits (one inserted after every 5 identical bits).
- Emits one-cycle valid pulses per payload bit, and flags stuff violations for the frame decoder.
- Regenerates the sampler's bit timing from the shared `en`, so no extra strobe wiring is needed.

Parameters:
- clk_speed_MHz, 100, system clock frequency in MHz.
- can_bit_rate_Kbits, 1000, CAN bit rate in kbit/s; N = clk_speed_MHz*1000/can_bit_rate_Kbits clocks per bit.
- stuff_len, 5, number of identical consecutive bits after which a stuff bit is expected.

Ports:
- clk  in  1  system clock (100 MHz).
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  frame active; same signal that drives the sampler's `en`; high from SOF until end of frame.
- din  in  1  sampled bit from the sampler's `dout`.
- destuff_en  in  1  1 = stuffed region (SOF through CRC sequence); 0 = pass-through (CRC delimiter onward).
- dout  out  1  destuffed data bit; held between pulses.
- dout_valid  out  1  one-clock pulse per delivered data bit.
- stuff_bit  out  1  one-clock pulse when a stuff bit is removed.
- stuff_err  out  1  sticky stuff-error flag; cleared when `en` goes low.

Behaviour:
- Reset: all outputs 0; bit counter 0; run_cnt 0; last_bit 1; state IDLE.
- Bit counter:
  - Width $clog2(N).
  - While en=1: counts 0..N-1, then wraps to 0.
  - en=0: cleared to 0 synchronously.
  - Identical to the sampler's counter, so both stay phase-locked.
- Bit tick: asserted when counter == N/2. This is the cycle after the sampler updates its output, so `din` is stable.
- All outputs are registered. Pulses appear the clock after the tick, i.e. the 51st rising edge with en=1 for N=100, then every N clocks.
- States:
  - IDLE: waiting for the first tick.
  - RUN: normal destuffing.
  - ERROR: stuff violation seen.
- IDLE, on first tick:
  - dout=din, dout_valid=1.
  - run_cnt=1, last_bit=din.
  - Go to RUN.
- RUN, tick with destuff_en=1:
  - If run_cnt==stuff_len and din!=last_bit (valid stuff bit): stuff_bit=1, no dout_valid; run_cnt=1, last_bit=din.
  - If run_cnt==stuff_len and din==last_bit: stuff_err=1, go to ERROR.
  - Otherwise: dout=din, dout_valid=1. If din==last_bit then run_cnt+1, else run_cnt=1. last_bit=din.
- RUN, tick with destuff_en=0:
  - Pass-through: dout=din, dout_valid=1.
  - run_cnt=0 and stays cleared. After destuff_en returns to 1, the next bit restarts the run at 1.
- ERROR:
  - No dout_valid or stuff_bit pulses.
  - stuff_err held at 1 until en=0.
- run_cnt is 3 bits and never exceeds stuff_len.
- en=0 at any time, including mid-bit or in ERROR:
  - Next clock: state IDLE, counter 0, run_cnt 0.
  - dout_valid, stuff_bit and stuff_err forced to 0; dout holds.
- destuff_en changing between ticks is legal. It is sampled only at the tick.
- rst_n asserted mid-frame: immediate return to reset values.

Optional Feature:
- Macro: CAN_RX_DESTUFF_STUFF_CNT_EN.
- With the macro defined:
  - Extra output stuff_cnt, 8 bits.
  - Increments on each stuff_bit pulse and saturates at 255.
  - Cleared on reset and when en=0.
- Without the macro: no port, no counter logic.

Test Plan:
- Stuff removal: N=100, en high, bits 0,0,0,0,0,1(stuff),1,0 with destuff_en=1 -> dout_valid 7 times with data 0,0,0,0,0,1,0; stuff_bit pulses once at the 6th tick; stuff_err=0.
- First-pulse latency: en rises, din=0 -> first dout_valid on the 51st clock edge with en high; subsequent pulses every 100 clocks.
- Stuff error: bits 1,1,1,1,1,1 with destuff_en=1 -> 5 dout_valid pulses; stuff_err=1 at the 6th tick and held; no further pulses until en=0, which clears stuff_err the next clock.
- Pass-through: destuff_en=0, seven 1s -> 7 dout_valid pulses, no stuff_bit, no stuff_err. destuff_en then set to 1 followed by 1,1,1,1,1,1 -> the 6th bit raises stuff_err (run restarted at the first stuffed-region bit).
- Abort: en dropped at counter=30 during a run of 4 identical bits -> outputs 0 next clock. Re-enable with 0,0 -> no stuff expected; run_cnt restarts at 1.
- Optional feature (macro defined): 300 valid stuff bits in one frame -> stuff_cnt=255 (saturated); en=0 -> stuff_cnt=0.

Source files
------------

// File: rtl/can_rx_destuff.sv
// can_rx_destuff: removes CAN stuff bits from the sampler stream, phase-locked to it through the shared en.
// Define CAN_RX_DESTUFF_STUFF_CNT_EN to add the saturating 8-bit stuff_cnt output.
module can_rx_destuff #(
    parameter int clk_speed_MHz      = 100,
    parameter int can_bit_rate_Kbits = 1000,
    parameter int stuff_len          = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       din,
    input  logic       destuff_en,
    output logic       dout,
    output logic       dout_valid,
    output logic       stuff_bit,
`ifdef CAN_RX_DESTUFF_STUFF_CNT_EN
    output logic [7:0] stuff_cnt,
    output logic       stuff_err
`else
    output logic       stuff_err
`endif
);
    localparam int N  = clk_speed_MHz * 1000 / can_bit_rate_Kbits;
    localparam int CW = N > 1 ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST    = CW'(N - 1);
    localparam logic [CW-1:0] MID     = CW'(N / 2);
    localparam logic [2:0]    RUN_MAX = 3'(stuff_len);

    typedef enum logic [1:0] {IDLE, RUN, ERROR} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    run_q, run_d;
    logic          last_q, last_d;
    logic          dout_q, dout_d;
    logic          valid_q, valid_d;
    logic          stuff_q, stuff_d;
    logic          err_q, err_d;
    logic          tick;

    // Counter mirrors the sampler's, so mid-bit is one cycle after din settles
    assign tick = en && cnt_q == MID;

    always_comb begin
        cnt_d   = !en || cnt_q == LAST ? '0 : cnt_q + 1'b1;
        state_d = state_q;
        run_d   = run_q;
        last_d  = last_q;
        dout_d  = dout_q;
        valid_d = 1'b0;
        stuff_d = 1'b0;
        err_d   = err_q;
        if (!en) begin
            state_d = IDLE;
            run_d   = 3'd0;
            err_d   = 1'b0;
        end else if (tick) begin
            case (state_q)
                IDLE: begin
                    dout_d  = din;
                    valid_d = 1'b1;
                    run_d   = 3'd1;
                    last_d  = din;
                    state_d = RUN;
                end
                RUN: begin
                    if (!destuff_en) begin
                        dout_d  = din;
                        valid_d = 1'b1;
                        run_d   = 3'd0;
                        last_d  = din;
                    end else if (run_q == RUN_MAX && din != last_q) begin
                        stuff_d = 1'b1;
                        run_d   = 3'd1;
                        last_d  = din;
                    end else if (run_q == RUN_MAX) begin
                        err_d   = 1'b1;
                        state_d = ERROR;
                    end else begin
                        dout_d  = din;
                        valid_d = 1'b1;
                        run_d   = din == last_q ? run_q + 3'd1 : 3'd1;
                        last_d  = din;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            run_q   <= 3'd0;
            last_q  <= 1'b1;
            dout_q  <= 1'b0;
            valid_q <= 1'b0;
            stuff_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            run_q   <= run_d;
            last_q  <= last_d;
            dout_q  <= dout_d;
            valid_q <= valid_d;
            stuff_q <= stuff_d;
            err_q   <= err_d;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = valid_q;
    assign stuff_bit  = stuff_q;
    assign stuff_err  = err_q;

`ifdef CAN_RX_DESTUFF_STUFF_CNT_EN
    logic [7:0] scnt_q, scnt_d;

    always_comb begin
        scnt_d = !en ? 8'd0 : stuff_d && scnt_q != 8'hFF ? scnt_q + 8'd1 : scnt_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) scnt_q <= 8'd0;
        else        scnt_q <= scnt_d;
    end

    assign stuff_cnt = scnt_q;
`endif
endmodule
